interrupt_controller: RTL
=========================

Name: interrupt_controller

Overview:
- Parametrised N-channel interrupt controller that replaces the hard-wired int0/int1 inputs of the 8-bit Processor.
- Detects rising edges on the interrupt lines, latches them as pending, and applies a software mask and fixed priority (lowest index wins).
- Presents one request at a time to the control unit, with a vectored ISR address and a request/acknowledge/done handshake.

Parameters:
- NUM_INT, 4, number of interrupt channels (1..16).
- ADDR_W, 8, width of the ISR address bus.
- VEC_BASE, 8'hF0, ISR address of channel 0.
- VEC_STRIDE, 2, address spacing between consecutive channel vectors.

Ports:
- clk  in  1  system clock, rising-edge active.
- reset  in  1  synchronous, active-high reset.
- intIn  in  NUM_INT  raw interrupt lines, already synchronous to clk.
- maskWr  in  1  one-cycle strobe; loads maskIn into the mask register.
- maskIn  in  NUM_INT  new mask value; 1 = channel masked.
- maskOut  out  NUM_INT  current mask register.
- pendingOut  out  NUM_INT  current pending register.
- intReq  out  1  request to the control unit.
- isrAddr  out  ADDR_W  vector of the requested or in-service channel.
- activeId  out  $clog2(NUM_INT) (min 1)  index of the requested or in-service channel.
- intAck  in  1  one-cycle pulse from the CPU: request taken.
- intDone  in  1  one-cycle pulse from the CPU: RETI executed.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset. All state changes happen on the rising edge of clk.
- Reset values:
  - maskOut=0 (all channels enabled), pendingOut=0, intReq=0, isrAddr=VEC_BASE, activeId=0, FSM=IDLE.
  - The edge-detect register loads intIn during reset, so a line already high at reset release is not an edge.
- Edge detect: pending[i] sets on the cycle after intIn[i] goes 0->1. Masked channels still latch pending; the mask only gates selection.
- Selection: winner = lowest index i with pending[i] & ~mask[i].
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: when any eligible channel exists, capture the winner into activeId and drive isrAddr=VEC_BASE+activeId*VEC_STRIDE (truncated to ADDR_W). Next cycle: REQ with intReq=1. Latency from edge to intReq = 2 cycles.
  - REQ: intReq held at 1; activeId and isrAddr frozen. A mask write or a new higher-priority edge does not retract or alter the request. On intAck: clear pending[activeId], intReq=0, go to SERVICE.
  - SERVICE: activeId and isrAddr held. On intDone, go to IDLE; a new selection may start on the next cycle.
- Simultaneous events:
  - A new edge on the channel being cleared by intAck in the same cycle: set wins, and the channel stays pending.
  - maskWr in the same cycle as selection: selection uses the old mask.
- Ignored inputs: intAck outside REQ, and intDone outside SERVICE (or IDLE when nesting is enabled).
- Reset mid-operation: returns to the reset values immediately, and the request is dropped.

Optional Feature:
- Macro: INTC_NEST_EN.
- With the macro defined:
  - An inService register (NUM_INT bits) tracks every channel currently being serviced.
  - In SERVICE, an eligible pending channel with a lower index than the current service level preempts it: go to REQ for that channel. On intAck, set its inService bit.
  - intDone clears the lowest set inService bit. If other bits remain set, stay in SERVICE with activeId = the new lowest set bit and isrAddr updated to match. Otherwise go to IDLE.
- Without the macro: no preemption; a single service level, exactly as described above.

Decomposition:
- Shared package intc_pkg holds:
  - the FSM state encoding (IDLE=2'd0, REQ=2'd1, SERVICE=2'd2);
  - the default VEC_BASE and VEC_STRIDE constants;
  - an id-width function (clog2, minimum 1).
- One sub-module: intc_prio_enc, a parametrised lowest-index-first priority encoder producing valid and index. The same encoder is reused for the inService lookup.

Test Plan (NUM_INT=4, VEC_BASE=F0, VEC_STRIDE=2):
- Pulse intIn[2] at cycle 10 -> intReq=1 at cycle 12, activeId=2, isrAddr=F4; intAck -> pending[2]=0, intReq=0; intDone -> IDLE.
- Raise intIn[1] and intIn[3] in the same cycle -> channel 1 served first (isrAddr=F2); channel 3 requested 2 cycles after intDone (isrAddr=F6).
- maskWr with maskIn=4'b0001, then pulse intIn[0] -> pendingOut=0001 and no intReq; then maskWr with 0000 -> intReq at cycle +2 with isrAddr=F0.
- Hold intIn[1] high through reset release -> no pending bit set; a later 0->1 transition on intIn[1] -> request.
- Assert reset while in REQ -> next cycle intReq=0, pendingOut=0, maskOut=0; intAck pulse issued after reset has no effect.
- With INTC_NEST_EN, servicing channel 3 while intIn[0] rises -> REQ for channel 0 (F0). First intDone -> SERVICE with activeId=3 (F6). Second intDone -> IDLE.

Source files
------------

// File: rtl/intc_pkg.sv
// intc_pkg: shared FSM encoding, default vector constants and id-width helper for interrupt_controller.
package intc_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;
  localparam logic [7:0] DEF_VEC_BASE = 8'hF0;
  localparam int DEF_VEC_STRIDE = 2;
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/intc_prio_enc.sv
// intc_prio_enc: lowest-index-first priority encoder producing valid and index.
module intc_prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] idx
);
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (req[i]) idx = W'(i);
  end
  assign valid = |req;
endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: N-channel edge-latched, masked, fixed-priority vectored interrupt controller.
// Define INTC_NEST_EN to enable nested (preemptive) servicing with an inService stack.
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int                NUM_INT    = 4,
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(DEF_VEC_BASE),
  parameter int                VEC_STRIDE = DEF_VEC_STRIDE
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_INT-1:0]           intIn,
  input  logic                         maskWr,
  input  logic [NUM_INT-1:0]           maskIn,
  output logic [NUM_INT-1:0]           maskOut,
  output logic [NUM_INT-1:0]           pendingOut,
  output logic                         intReq,
  output logic [ADDR_W-1:0]            isrAddr,
  output logic [id_w(NUM_INT)-1:0]     activeId,
  input  logic                         intAck,
  input  logic                         intDone
);
  localparam int IW = id_w(NUM_INT);
  state_t state_q, state_d;
  logic [NUM_INT-1:0] mask_q, mask_d, pend_q, pend_d, prev_q, clr;
  logic [IW-1:0] id_q, id_d, win_id;
  logic win_v;
  intc_prio_enc #(.N(NUM_INT), .W(IW)) u_win (.req(pend_q & ~mask_q), .valid(win_v), .idx(win_id));
`ifdef INTC_NEST_EN
  logic [NUM_INT-1:0] ins_q, ins_d, ins_rest;
  logic [IW-1:0] rest_id;
  logic rest_v;
  // In SERVICE id_q is always the lowest set inService bit, so dropping it leaves the rest.
  assign ins_rest = ins_q & (ins_q - NUM_INT'(1));
  intc_prio_enc #(.N(NUM_INT), .W(IW)) u_ins (.req(ins_rest), .valid(rest_v), .idx(rest_id));
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
      pend_q  <= '0;
      prev_q  <= intIn;
      id_q    <= '0;
`ifdef INTC_NEST_EN
      ins_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      prev_q  <= intIn;
      id_q    <= id_d;
`ifdef INTC_NEST_EN
      ins_q   <= ins_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    clr     = '0;
    mask_d  = maskWr ? maskIn : mask_q;
`ifdef INTC_NEST_EN
    ins_d   = ins_q;
`endif
    unique case (state_q)
      IDLE: begin
        state_d = win_v ? REQ : IDLE;
        id_d    = win_v ? win_id : id_q;
      end
      REQ: if (intAck) begin
        state_d = SERVICE;
        clr     = NUM_INT'(1) << id_q;
`ifdef INTC_NEST_EN
        ins_d   = ins_q | (NUM_INT'(1) << id_q);
`endif
      end
      SERVICE: begin
`ifdef INTC_NEST_EN
        if (intDone) begin
          ins_d   = ins_rest;
          state_d = rest_v ? SERVICE : IDLE;
          id_d    = rest_v ? rest_id : id_q;
        end else if (win_v && win_id < id_q) begin
          state_d = REQ;
          id_d    = win_id;
        end
`else
        state_d = intDone ? IDLE : SERVICE;
`endif
      end
      default: state_d = IDLE;
    endcase
    pend_d = (pend_q & ~clr) | (intIn & ~prev_q);
  end
  always_comb begin
    intReq     = state_q == REQ;
    activeId   = id_q;
    isrAddr    = VEC_BASE + ADDR_W'(int'(id_q) * VEC_STRIDE);
    maskOut    = mask_q;
    pendingOut = pend_q;
  end
endmodule
